// File: rtl/vga_pkg.sv
// Shared geometry and types for the VGA text tile buffer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_pkg;

  localparam int NUM_COLS   = 80;
  localparam int NUM_ROWS   = 30;
  localparam int NUM_TILES  = NUM_COLS * NUM_ROWS;
  localparam int CHAR_W     = 7;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int NUM_LANES  = DATA_W / 8;

  // Tiles are interleaved over four banks by index mod 4.
  localparam int NUM_BANKS  = 4;
  localparam int BANK_DEPTH = NUM_TILES / NUM_BANKS;
  localparam int BANK_AW    = ADDR_W - 2;

  typedef logic [ADDR_W-1:0]  tile_idx_t;
  typedef logic [CHAR_W-1:0]  char_t;
  typedef logic [BANK_AW-1:0] bank_addr_t;

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port tile RAM bank: one write port, one registered read port.
// Latency: read data registered, valid one cycle after the address; read-first.
// Backpressure: none, both ports accept every cycle.
module tile_ram
  import vga_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  bank_addr_t waddr_i,
  input  char_t      wdata_i,
  input  bank_addr_t raddr_i,
  output char_t      rdata_o
);

  // Zero at power-up through memory initialisation; reset never clears it.
  char_t mem [BANK_DEPTH] = '{default: '0};
  char_t rd_d;
  char_t rd_q;

  // Combinational array lookup; addresses past the bank depth read as zero.
  always_comb begin
    rd_d = '0;
    if (raddr_i < BANK_AW'(BANK_DEPTH)) begin
      rd_d = mem[raddr_i];
    end
  end

  // Read register and write port share an edge, so a same-address read sees old data.
  always_ff @(posedge clk_i) begin
    rd_q <= rd_d;
    if (we_i && (waddr_i < BANK_AW'(BANK_DEPTH))) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/buffer.sv
// Text-mode tile buffer: 4-lane strobed bus writes, one display/bus read per cycle.
// Latency: dout_o valid one cycle after the read address is sampled; read-first.
// Backpressure: none, no stall or handshake on either port.
module buffer
  import vga_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [3:0]        w_strb_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  input  logic              r_req_i,
  input  logic [6:0]        col_r_i,
  input  logic [4:0]        row_r_i,
  output logic [CHAR_W-1:0] dout_o
);

  logic        bank_we    [NUM_BANKS];
  bank_addr_t  bank_waddr [NUM_BANKS];
  char_t       bank_wdata [NUM_BANKS];
  char_t       bank_rdata [NUM_BANKS];
  logic [1:0]  lane_sel   [NUM_BANKS];
  logic [12:0] tgt_idx    [NUM_BANKS];

  tile_idx_t   rd_idx;
  logic        rd_ok;
  logic [1:0]  sel_d, sel_q;
  logic        ok_d, ok_q;

  // Route each byte lane to the bank holding its target tile; lanes past the end are dropped.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      lane_sel[b]   = 2'(b) - w_addr_i[1:0];
      tgt_idx[b]    = {1'b0, w_addr_i} + {11'b0, lane_sel[b]};
      bank_we[b]    = wr_en_i && !rst_i && w_strb_i[lane_sel[b]] &&
                      (tgt_idx[b] < 13'(NUM_TILES));
      bank_waddr[b] = tgt_idx[b][11:2];
      bank_wdata[b] = din_i[{lane_sel[b], 3'b000} +: CHAR_W];
    end
  end

  // Pick bus read-back or display column/row, and flag out-of-range reads.
  always_comb begin
    rd_idx = '0;
    rd_ok  = 1'b0;
    if (r_req_i) begin
      rd_idx = r_addr_i;
      rd_ok  = (r_addr_i < ADDR_W'(NUM_TILES));
    end else begin
      rd_idx = ({7'b0, row_r_i} * ADDR_W'(NUM_COLS)) + {5'b0, col_r_i};
      rd_ok  = (col_r_i < 7'(NUM_COLS)) && (row_r_i < 5'(NUM_ROWS));
    end
    sel_d = rd_idx[1:0];
    ok_d  = rd_ok;
  end

  // Bank select and range flag travel alongside the registered bank reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q <= '0;
      ok_q  <= 1'b0;
    end else begin
      sel_q <= sel_d;
      ok_q  <= ok_d;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    tile_ram u_ram (
      .clk_i   (clk_i),
      .we_i    (bank_we[g]),
      .waddr_i (bank_waddr[g]),
      .wdata_i (bank_wdata[g]),
      .raddr_i (rd_idx[11:2]),
      .rdata_o (bank_rdata[g])
    );
  end

  assign dout_o = ok_q ? bank_rdata[sel_q] : '0;

endmodule

// File: tb/tb_buffer.sv
module tb_buffer;

  localparam int TILES = 2400;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [11:0] w_addr;
  logic [3:0]  w_strb;
  logic [31:0] din;
  logic [11:0] r_addr;
  logic        r_req;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [6:0]  dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] model_mem [TILES];

  buffer dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_en_i  (wr_en),
    .w_addr_i (w_addr),
    .w_strb_i (w_strb),
    .din_i    (din),
    .r_addr_i (r_addr),
    .r_req_i  (r_req),
    .col_r_i  (col),
    .row_r_i  (row),
    .dout_o   (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: dout=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Tile value the display/bus read should return, from the current inputs.
  function automatic logic [6:0] model_read();
    if (r_req) begin
      if (int'(r_addr) < TILES) return model_mem[r_addr];
      return 7'd0;
    end
    if (int'(col) < 80 && int'(row) < 30) return model_mem[int'(row) * 80 + int'(col)];
    return 7'd0;
  endfunction

  task automatic model_write();
    if (wr_en && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (w_strb[k] && (int'(w_addr) + k < TILES)) begin
          model_mem[int'(w_addr) + k] = din[8*k +: 7];
        end
      end
    end
  endtask

  // One clock: expectation taken before the write (read-first), checked #1 after the edge.
  task automatic step(input string tag);
    logic [6:0] exp;
    exp = rst ? 7'd0 : model_read();
    @(posedge clk);
    model_write();
    #1;
    check(tag, dout, exp);
    @(negedge clk);
  endtask

  task automatic set_rc(input int c, input int r);
    col = 7'(c);
    row = 5'(r);
  endtask

  initial begin
    for (int i = 0; i < TILES; i++) model_mem[i] = 7'd0;
    rst = 1'b1; wr_en = 1'b0; w_addr = '0; w_strb = '0; din = '0;
    r_addr = '0; r_req = 1'b0; col = '0; row = '0;
    @(negedge clk);
    @(negedge clk);
    step("reset_state");
    rst = 1'b0;

    // Power-up contents are all zero.
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        set_rc(c, r);
        step("init_sweep");
      end

    // Write tile n while reading tile n: old value (0) must come back.
    for (int n = 0; n < TILES; n++) begin
      wr_en = 1'b1; w_strb = 4'b0001; w_addr = 12'(n); din = 32'(n);
      set_rc(n % 80, n / 80);
      step("rdw_first");
    end
    wr_en = 1'b0;

    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        set_rc(c, r);
        step("fill_sweep");
        if (c == 5 && r == 1)   check("c5r1", dout, 7'd85);
        if (c == 79 && r == 29) check("c79r29", dout, 7'd95);
      end

    // Full strobe write of four tiles.
    wr_en = 1'b1; w_strb = 4'b1111; w_addr = 12'd4; din = 32'hBBBBBBBB;
    set_rc(0, 0);
    step("full_strb_wr");
    wr_en = 1'b0;
    for (int c = 4; c < 8; c++) begin
      set_rc(c, 0);
      step("full_strb_rd");
      check("full_strb_3b", dout, 7'h3B);
    end

    // Zero strobe writes nothing.
    wr_en = 1'b1; w_strb = 4'b0000; w_addr = 12'd4; din = 32'h44444444;
    step("zero_strb_wr");
    wr_en = 1'b0;
    set_rc(4, 0);
    step("zero_strb_rd");
    check("zero_strb_3b", dout, 7'h3B);

    // Write straddling the end of the array.
    wr_en = 1'b1; w_strb = 4'b1111; w_addr = 12'd2398; din = 32'h04030201;
    step("bound_wr");
    wr_en = 1'b0;
    set_rc(78, 29); step("bound_2398"); check("bound_2398_k", dout, 7'd1);
    set_rc(79, 29); step("bound_2399"); check("bound_2399_k", dout, 7'd2);
    set_rc(77, 29); step("bound_2397"); check("bound_2397_k", dout, 7'd93);
    set_rc(0, 0);   step("bound_0");    check("bound_0_k", dout, 7'd0);

    // Out-of-range display coordinates.
    set_rc(80, 0);   step("col80");  check("col80_k", dout, 7'd0);
    set_rc(0, 30);   step("row30");  check("row30_k", dout, 7'd0);
    set_rc(127, 31); step("maxcr");  check("maxcr_k", dout, 7'd0);

    // Reset clears dout and blocks writes, memory retained.
    rst = 1'b1; wr_en = 1'b1; w_strb = 4'b0001; w_addr = 12'd4; din = 32'h11;
    set_rc(4, 0);
    step("rst_dout");
    check("rst_dout_k", dout, 7'd0);
    rst = 1'b0; wr_en = 1'b0;
    step("rst_keep");
    check("rst_keep_k", dout, 7'h3B);

    // Bus read-back overrides col/row.
    r_req = 1'b1; r_addr = 12'd4; set_rc(10, 3);
    step("rb_4");    check("rb_4_k", dout, 7'h3B);
    r_addr = 12'd2400;
    step("rb_2400"); check("rb_2400_k", dout, 7'd0);
    r_req = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      wr_en  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       w_addr = 12'($urandom_range(2392, 2405));
        1:       w_addr = 12'($urandom_range(0, 4095));
        default: w_addr = 12'($urandom_range(0, 2399));
      endcase
      w_strb = 4'($urandom);
      din    = $urandom;
      r_req  = $urandom_range(0, 3) == 0;
      r_addr = 12'($urandom_range(0, 2410));
      set_rc($urandom_range(0, 84), $urandom_range(0, 31));
      step("random");
    end
    rst = 1'b0; wr_en = 1'b0; r_req = 1'b0;

    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        set_rc(c, r);
        step("final_sweep");
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
